// File: rtl/scalar_integer_issue_ctl.sv
// Issue controller and S-register scoreboard for the 2-cycle scalar integer
// functional unit (104 sum, 105 difference, 106 pop/parity, 107 leading zeros).
// Accepts instructions over valid/ready and stalls on S-register hazards.
// Drives the FU operands and tracks each in-flight result through a short
// shift register. It then raises the registered Si writeback strobe.
module scalar_integer_issue_ctl #(
  parameter int FU_LAT   = 2,
  parameter int NUM_SREG = 8,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic [6:0]          i_Instr,
  input  logic                i_X,
  input  logic [IDX_W-1:0]    i_I,
  input  logic [IDX_W-1:0]    i_J,
  input  logic [IDX_W-1:0]    i_K,
  input  logic [63:0]         i_Sj_Data,
  input  logic [63:0]         i_Sk_Data,
  output logic [63:0]         o_Fu_Sj,
  output logic [63:0]         o_Fu_Sk,
  output logic [6:0]          o_Fu_Instr,
  input  logic [63:0]         i_Fu_Si,
  output logic                o_Wr_En,
  output logic [IDX_W-1:0]    o_Wr_Idx,
  output logic [63:0]         o_Wr_Data,
  output logic [NUM_SREG-1:0] o_Busy,
  output logic                o_Illegal,
  input  logic                i_Flush
);

  localparam int DEPTH = FU_LAT + 1;

  localparam logic [6:0] OP_SUM = 7'o104;
  localparam logic [6:0] OP_DIF = 7'o105;
  localparam logic [6:0] OP_POP = 7'o106;
  localparam logic [6:0] OP_LZC = 7'o107;
  localparam logic [6:0] OP_NOP = 7'o000;

  logic [NUM_SREG-1:0] busy;
  logic [NUM_SREG-1:0] busy_nxt;
  logic [DEPTH-1:0]    trk_v;
  logic [IDX_W-1:0]    trk_idx [DEPTH];

  logic legal;
  logic uses_k;
  logic hazard;
  logic issue;
  logic issue_ok;
  logic issue_bad;
  logic retire;

  // Decode, hazard detection and handshake.
  always_comb begin
    legal     = (i_Instr == OP_SUM) || (i_Instr == OP_DIF) ||
                (i_Instr == OP_POP) || (i_Instr == OP_LZC);
    uses_k    = (i_Instr == OP_SUM) || (i_Instr == OP_DIF);
    hazard    = legal & (busy[i_J] | busy[i_I] | (busy[i_K] & uses_k));
    o_Ready   = rst_n & ~i_Flush & ~hazard;
    issue     = i_Valid & o_Ready;
    issue_ok  = issue & legal;
    issue_bad = issue & ~legal;
    retire    = trk_v[DEPTH-1];
  end

  // Scoreboard update: retire clears, a same-edge issue set wins over the clear.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 0; r < NUM_SREG; r++) begin
      if (retire && (trk_idx[DEPTH-1] == IDX_W'(r)))
        busy_nxt[r] = 1'b0;
      if (issue_ok && (i_I == IDX_W'(r)))
        busy_nxt[r] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else if (i_Flush)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  // In-flight tracking; the last stage is the writeback strobe itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v <= '0;
      for (int unsigned s = 0; s < DEPTH; s++)
        trk_idx[s] <= '0;
    end else begin
      if (i_Flush)
        trk_v <= '0;
      else
        trk_v <= {trk_v[DEPTH-2:0], issue_ok};
      trk_idx[0] <= i_I;
      for (int unsigned s = 1; s < DEPTH; s++)
        trk_idx[s] <= trk_idx[s-1];
    end
  end

  // FU operand and instruction drive; operands hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_Fu_Sj    <= '0;
      o_Fu_Sk    <= '0;
      o_Fu_Instr <= OP_NOP;
      o_Illegal  <= 1'b0;
    end else begin
      o_Illegal <= issue_bad;
      if (issue_ok) begin
        o_Fu_Sj    <= i_Sj_Data;
        o_Fu_Instr <= i_Instr;
        if (uses_k)
          o_Fu_Sk <= i_Sk_Data;
        else if (i_Instr == OP_POP)
          o_Fu_Sk <= {63'b0, i_X};
        else
          o_Fu_Sk <= '0;
      end else begin
        o_Fu_Instr <= OP_NOP;
      end
    end
  end

  assign o_Wr_En   = trk_v[DEPTH-1];
  assign o_Wr_Idx  = trk_idx[DEPTH-1];
  assign o_Wr_Data = i_Fu_Si;
  assign o_Busy    = busy;

endmodule

// File: tb/tb_scalar_integer_issue_ctl.sv
// Self-checking bench for scalar_integer_issue_ctl: behavioural FU and S
// register file around the DUT, scoreboard of expected writebacks.
module tb_scalar_integer_issue_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Valid;
  logic        o_Ready;
  logic [6:0]  i_Instr;
  logic        i_X;
  logic [2:0]  i_I, i_J, i_K;
  logic [63:0] i_Sj_Data, i_Sk_Data;
  logic [63:0] o_Fu_Sj, o_Fu_Sk;
  logic [6:0]  o_Fu_Instr;
  logic [63:0] i_Fu_Si;
  logic        o_Wr_En;
  logic [2:0]  o_Wr_Idx;
  logic [63:0] o_Wr_Data;
  logic [7:0]  o_Busy;
  logic        o_Illegal;
  logic        i_Flush;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] data;
    int          at;
  } wr_t;
  wr_t exp_q[$];

  logic [63:0] sreg [8];
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [63:0] pl_data;
  logic        sk_force;

  logic [63:0] cap_sj, cap_sk;
  logic [6:0]  cap_op;

  scalar_integer_issue_ctl #(.FU_LAT(2), .NUM_SREG(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Instr(i_Instr), .i_X(i_X), .i_I(i_I), .i_J(i_J), .i_K(i_K),
    .i_Sj_Data(i_Sj_Data), .i_Sk_Data(i_Sk_Data),
    .o_Fu_Sj(o_Fu_Sj), .o_Fu_Sk(o_Fu_Sk), .o_Fu_Instr(o_Fu_Instr),
    .i_Fu_Si(i_Fu_Si), .o_Wr_En(o_Wr_En), .o_Wr_Idx(o_Wr_Idx),
    .o_Wr_Data(o_Wr_Data), .o_Busy(o_Busy), .o_Illegal(o_Illegal),
    .i_Flush(i_Flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign i_Sj_Data = sreg[i_J];
  assign i_Sk_Data = sk_force ? 64'hDEAD : sreg[i_K];

  function automatic logic [63:0] lzc(input logic [63:0] v);
    logic [63:0] n;
    n = 64;
    for (int b = 63; b >= 0; b--)
      if (v[b]) begin
        n = 64'(63 - b);
        break;
      end
    return n;
  endfunction

  // Behavioural FU: captures operands one edge after issue, result one edge later.
  always @(posedge clk) begin
    cap_sj <= o_Fu_Sj;
    cap_sk <= o_Fu_Sk;
    cap_op <= o_Fu_Instr;
    case (cap_op)
      7'o104:  i_Fu_Si <= cap_sj + cap_sk;
      7'o105:  i_Fu_Si <= cap_sj - cap_sk;
      7'o106:  i_Fu_Si <= cap_sk[0] ? {63'b0, ^cap_sj} : 64'($countones(cap_sj));
      7'o107:  i_Fu_Si <= lzc(cap_sj);
      default: i_Fu_Si <= 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  end

  // S register file: preload port plus DUT writeback.
  always @(posedge clk) begin
    if (pl_en) sreg[pl_idx] <= pl_data;
    if (o_Wr_En) sreg[o_Wr_Idx] <= o_Wr_Data;
  end

  // Writeback monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_Wr_En) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write idx=%0d data=%0h cyc=%0d", o_Wr_Idx, o_Wr_Data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (o_Wr_Idx !== e.idx || o_Wr_Data !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL writeback got idx=%0d data=%0h cyc=%0d expected idx=%0d data=%0h cyc=%0d",
                   o_Wr_Idx, o_Wr_Data, cyc, e.idx, e.data, e.at);
        end
      end
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [63:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Starts and ends at a negedge; returns the number of stalled cycles.
  task automatic issue(input logic [6:0] op, input logic x, input logic [2:0] i,
                       input logic [2:0] j, input logic [2:0] k,
                       input logic push, input logic [63:0] exp_data,
                       output int stalls);
    wr_t e;
    i_Valid = 1'b1; i_Instr = op; i_X = x; i_I = i; i_J = j; i_K = k;
    stalls = 0;
    #1;
    while (!o_Ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!o_Ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout op=%0o ready=%b", op, o_Ready);
    end
    if (push) begin
      e.idx = i; e.data = exp_data; e.at = cyc + 3;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    i_Valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (o_Ready !== 1'b0 || o_Busy !== 8'h00 || o_Wr_En !== 1'b0 || o_Fu_Instr !== 7'o000 ||
        o_Illegal !== 1'b0 || o_Fu_Sj !== 64'h0 || o_Fu_Sk !== 64'h0 || o_Wr_Idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%h wr=%b instr=%0o ill=%b sj=%0h sk=%0h idx=%0d expected all zero",
               o_Ready, o_Busy, o_Wr_En, o_Fu_Instr, o_Illegal, o_Fu_Sj, o_Fu_Sk, o_Wr_Idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_Ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b expected 1", o_Ready);
    end
    @(negedge clk);
  endtask

  task automatic test_sum;
    int st;
    logic [7:0] exp_busy [4] = '{8'h08, 8'h08, 8'h08, 8'h00};
    preload(3'd1, 64'd5);
    preload(3'd2, 64'd7);
    issue(7'o104, 1'b0, 3'd3, 3'd1, 3'd2, 1'b1, 64'd12, st);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (o_Busy !== exp_busy[n]) begin
        errors++;
        $display("FAIL sum_busy t+%0d got %h expected %h", n, o_Busy, exp_busy[n]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_raw;
    int st;
    issue(7'o104, 1'b0, 3'd3, 3'd1, 3'd2, 1'b1, 64'd12, st);
    issue(7'o105, 1'b0, 3'd4, 3'd3, 3'd1, 1'b1, 64'd7, st);
    checks++;
    if (st != 3) begin
      errors++;
      $display("FAIL raw_stall_cycles got %0d expected 3", st);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pop_parity;
    int st;
    preload(3'd1, 64'hFF00FF00FF00FF00);
    sk_force = 1'b1;
    issue(7'o106, 1'b0, 3'd2, 3'd1, 3'd3, 1'b1, 64'd32, st);
    checks++;
    if (o_Fu_Sk !== 64'd0 || o_Fu_Instr !== 7'o106) begin
      errors++;
      $display("FAIL pop_operand sk=%0h instr=%0o expected sk=0 instr=106", o_Fu_Sk, o_Fu_Instr);
    end
    preload(3'd1, 64'd7);
    issue(7'o106, 1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 64'd1, st);
    checks++;
    if (o_Fu_Sk !== 64'd1) begin
      errors++;
      $display("FAIL parity_operand sk=%0h expected 1", o_Fu_Sk);
    end
    sk_force = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int st;
    preload(3'd1, 64'd0);
    preload(3'd5, 64'd1);
    issue(7'o107, 1'b0, 3'd6, 3'd1, 3'd0, 1'b1, 64'd64, st);
    issue(7'o107, 1'b0, 3'd4, 3'd5, 3'd0, 1'b1, 64'd63, st);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL back_to_back_stall got %0d expected 0", st);
    end
    checks++;
    if (o_Busy !== 8'h50) begin
      errors++;
      $display("FAIL back_to_back_busy got %h expected 50", o_Busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal;
    int st;
    issue(7'o110, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, st);
    checks++;
    if (st != 0 || o_Illegal !== 1'b1 || o_Busy !== 8'h00 || o_Fu_Instr !== 7'o000) begin
      errors++;
      $display("FAIL illegal_pulse stall=%0d ill=%b busy=%h instr=%0o expected 0 1 00 0",
               st, o_Illegal, o_Busy, o_Fu_Instr);
    end
    @(negedge clk);
    checks++;
    if (o_Illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_one_cycle got %b expected 0", o_Illegal);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush;
    int st;
    issue(7'o104, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, st);
    i_Flush = 1'b1;
    i_Valid = 1'b1; i_Instr = 7'o104; i_I = 3'd5; i_J = 3'd6; i_K = 3'd7;
    #1;
    checks++;
    if (o_Ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b expected 0", o_Ready);
    end
    @(negedge clk);
    i_Flush = 1'b0; i_Valid = 1'b0;
    checks++;
    if (o_Busy !== 8'h00 || o_Fu_Instr !== 7'o000 || o_Wr_En !== 1'b0) begin
      errors++;
      $display("FAIL flush_state busy=%h instr=%0o wr=%b expected 00 0 0", o_Busy, o_Fu_Instr, o_Wr_En);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (o_Wr_En !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_write got %b expected 0", o_Wr_En);
      end
    end
  endtask

  task automatic test_reset_midop;
    int st;
    issue(7'o104, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, st);
    rst_n = 1'b0;
    i_Valid = 1'b1; i_Instr = 7'o104; i_I = 3'd5; i_J = 3'd6; i_K = 3'd7;
    #1;
    checks++;
    if (o_Ready !== 1'b0 || o_Busy !== 8'h00) begin
      errors++;
      $display("FAIL reset_midop ready=%b busy=%h expected 0 00", o_Ready, o_Busy);
    end
    @(negedge clk);
    checks++;
    if (o_Ready !== 1'b0 || o_Wr_En !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold ready=%b wr=%b expected 0 0", o_Ready, o_Wr_En);
    end
    i_Valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (o_Wr_En !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_write got %b expected 0", o_Wr_En);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; i_Valid = 1'b0; i_Instr = 7'o000; i_X = 1'b0;
    i_I = '0; i_J = '0; i_K = '0; i_Flush = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0; sk_force = 1'b0;
    for (int r = 0; r < 8; r++) sreg[r] = '0;
    test_reset();
    test_sum();
    test_raw();
    test_pop_parity();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_midop();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_integer_issue_ctl.md
Name: scalar_integer_issue_ctl

Overview:
- Issue controller and S-register scoreboard for the 2-cycle scalar integer functional unit (opcodes 104–107 octal: sum, difference, population/parity, leading zero count).
- Accepts decoded instructions from the issue stage over a valid/ready handshake.
- Stalls on S-register hazards, drives the FU operand/instruction inputs, tracks in-flight results and produces the Si writeback to the S register file.
- Issue rate is one instruction per cycle when there are no hazards.

Parameters:
- FU_LAT, 2: FU functional time in clocks (input capture to o_Si update).
- NUM_SREG, 8: number of S registers.
- IDX_W, 3: S register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_Valid  in  1  issue stage presents an instruction
- o_Ready  out  1  instruction accepted at this edge if i_Valid
- i_Instr  in  7  opcode (7'o104..7'o107)
- i_X  in  1  sub-op for 106 (0 = population, 1 = parity)
- i_I, i_J, i_K  in  IDX_W each  Si, Sj, Sk indices
- i_Sj_Data, i_Sk_Data  in  64 each  register file read data for Sj, Sk
- o_Fu_Sj, o_Fu_Sk  out  64 each  FU operands
- o_Fu_Instr  out  7  FU instruction (7'o000 = no-op)
- i_Fu_Si  in  64  FU result
- o_Wr_En  out  1  S register write strobe
- o_Wr_Idx  out  IDX_W  write index
- o_Wr_Data  out  64  write data
- o_Busy  out  NUM_SREG  scoreboard reservation bits
- o_Illegal  out  1  one-cycle pulse: rejected opcode
- i_Flush  in  1  kill all in-flight operations

Behaviour:
- Reset (async, rst_n low):
  - busy=0, pipeline valid bits=0.
  - o_Fu_Sj/o_Fu_Sk/o_Fu_Instr=0, o_Wr_En=0, o_Wr_Idx=0, o_Illegal=0.
  - o_Ready is forced 0 while rst_n is low.
- Hazard and o_Ready (combinational):
  - Hazard = busy[i_J] | busy[i_I] | (busy[i_K] & opcode in {104,105}).
  - o_Ready = rst_n & ~i_Flush & ~hazard.
  - Opcodes outside 104–107 never stall; they are handled as illegal below.
- Issue at edge t (i_Valid & o_Ready, legal opcode):
  - o_Fu_Sj <= i_Sj_Data; o_Fu_Instr <= i_Instr; busy[i_I] <= 1.
  - Launch a valid bit with index i_I into the FU_LAT+1 deep tracking shift register.
  - o_Fu_Sk source by opcode:
    - 104/105: i_Sk_Data.
    - 106: {63'b0, i_X}; register data is ignored.
    - 107: 0.
- Idle or illegal cycle: o_Fu_Instr <= 7'o000; operands hold.
- Illegal opcode accepted:
  - o_Illegal pulses 1 for the cycle after edge t.
  - No scoreboard change, no writeback.
- Timing:
  - FU captures operands at t+1 and updates o_Si at t+2.
  - o_Wr_En is registered and high for exactly the cycle between edges t+2 and t+3.
  - During that cycle: o_Wr_Idx = tracked i_I, o_Wr_Data = i_Fu_Si (combinational pass-through).
  - Register file writes at edge t+3.
- Busy clear:
  - busy[idx] clears at edge t+3.
  - A dependent instruction sees o_Ready=1 after t+3, issues no earlier than t+4, and reads updated data. No bypass.
  - If a new issue sets busy for the same index at the same edge as the clear, the set wins. WAW stalling makes this case unreachable; the implementation must still give set priority.
- Back-to-back independent issues produce consecutive o_Wr_En cycles, one per issue, in order.
- i_Flush (sampled at edge):
  - Clears all busy bits and tracking valid bits.
  - o_Fu_Instr <= 0, o_Wr_En <= 0 from the next cycle.
  - No write occurs for any instruction issued before the flush.
  - Flush takes priority over a simultaneous i_Valid (o_Ready=0).
- Reset mid-operation: in-flight results are discarded and no write follows.
- No overflow detection. Result width and arithmetic are defined by the FU.

Test Plan:
- Independent sum: S1=5, S2=7; issue 104 i=3 j=1 k=2 at edge t -> o_Wr_En=1, o_Wr_Idx=3, o_Wr_Data=12 in the cycle before t+3; o_Busy[3] set t..t+3.
- RAW stall: sum into S3 at t, then 105 i=4 j=3 k=1 presented at t+1 -> o_Ready=0 until after t+3; issue at t+4; S4 = 12-5 = 7 written at t+7.
- Pop/parity: S1=64'hFF00FF00FF00FF00; 106 x=0 i=2 j=1 -> S2=32. Then 106 x=1 with S1=7 -> S2=1. Check o_Fu_Sk = 0 and 1 respectively, regardless of i_Sk_Data = 64'hDEAD.
- LZC and pipelining: 107 with S1=0 then 107 with S5=1, issued on consecutive cycles -> writes 64 then 63 on consecutive cycles.
- Illegal: i_Instr=7'o110 -> accepted, o_Illegal pulse, o_Busy unchanged, no o_Wr_En.
- Flush/reset: issue 104 at t, i_Flush at t+1 -> no o_Wr_En, o_Busy=0 after t+1. Repeat with rst_n low at t+1 -> same result, and o_Ready=0 while rst_n is low.
